// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: immediate type codes, opcode constants and the shared immediate decoder.
// Latency: none, pure combinational function.
// Backpressure: not applicable. Build option IMMGEN_RVC_EN enables compressed decode.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Immediate is always produced sign-extended to 64 bits; an XLEN=32 user
  // keeps the low 32 bits, which is exact for every format.
  typedef struct packed {
    imm_type_e   typ;
    logic [63:0] imm;
  } imm_dec_t;

  function automatic imm_dec_t decode_base(input logic [31:0] instr);
    imm_dec_t d;
    d.typ = IMM_NONE;
    d.imm = '0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        d.typ = IMM_I;
        d.imm = {{52{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        d.typ = IMM_S;
        d.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        d.typ = IMM_B;
        d.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_JAL: begin
        d.typ = IMM_J;
        d.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        d.typ = IMM_U;
        d.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      end
      OP_SYSTEM: begin
        // Only the CSR*I forms carry a zimm; funct3[2] selects them.
        if (instr[14]) begin
          d.typ = IMM_Z;
          d.imm = {59'b0, instr[19:15]};
        end
      end
      default: ;
    endcase
    return d;
  endfunction

`ifdef IMMGEN_RVC_EN
  function automatic imm_dec_t decode_rvc(input logic [15:0] c);
    imm_dec_t d;
    d.typ = IMM_NONE;
    d.imm = '0;
    case ({c[15:13], c[1:0]})
      5'b000_01, 5'b010_01: begin  // C.ADDI, C.LI
        d.typ = IMM_I;
        d.imm = {{58{c[12]}}, c[12], c[6:2]};
      end
      5'b011_01: begin             // C.LUI; rd==x2 is C.ADDI16SP, no immediate reported
        if (c[11:7] != 5'd2) begin
          d.typ = IMM_U;
          d.imm = {{46{c[12]}}, c[12], c[6:2], 12'b0};
        end
      end
      5'b010_00: begin             // C.LW
        d.typ = IMM_I;
        d.imm = {57'b0, c[5], c[12:10], c[6], 2'b00};
      end
      5'b110_00: begin             // C.SW
        d.typ = IMM_S;
        d.imm = {57'b0, c[5], c[12:10], c[6], 2'b00};
      end
      5'b001_01, 5'b101_01: begin  // C.JAL, C.J
        d.typ = IMM_J;
        d.imm = {{52{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
      end
      5'b110_01, 5'b111_01: begin  // C.BEQZ, C.BNEZ
        d.typ = IMM_B;
        d.imm = {{55{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
      end
      default: ;
    endcase
    return d;
  endfunction
`endif

  function automatic imm_dec_t decode_imm(input logic [31:0] instr);
`ifdef IMMGEN_RVC_EN
    if (instr[1:0] != 2'b11) return decode_rvc(instr[15:0]);
`endif
    return decode_base(instr);
  endfunction

endpackage

// File: rtl/imm_pipe_stage.sv
// imm_pipe_stage: one valid/ready register slice with synchronous flush.
// Latency: 1 cycle.
// Backpressure: up_rdy = !dn_vld || dn_rdy, so a full slice drains and refills in the same cycle.
module imm_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [W-1:0] up_dat,
  output logic         dn_vld,
  input  logic         dn_rdy,
  output logic [W-1:0] dn_dat
);

  assign up_rdy = !dn_vld || dn_rdy;

  // Occupancy: flush beats accept; otherwise refill or empty whenever downstream can take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dn_vld <= 1'b0;
    else if (flush)  dn_vld <= 1'b0;
    else if (up_rdy) dn_vld <= up_vld;
  end

  // Payload only moves on an actual accept, so an empty slice holds still.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                dn_dat <= '0;
    else if (up_vld && up_rdy && !flush)    dn_dat <= up_dat;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator feeding a STAGES-deep valid/ready pipe with flush.
// Latency: STAGES cycles from accept to valid_o; sustains one instruction per cycle.
// Backpressure: ready_i low holds outputs stable and ready_o falls once all stages fill; IMMGEN_RVC_EN adds RVC decode.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       imm_type_o,
  output logic [31:0]     instr_o
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_type_e       typ;
    logic [31:0]     instr;
  } pay_t;

  localparam int PW = $bits(pay_t);

  imm_dec_t dec;
  pay_t     head;
  logic     unused_dec_hi;

  // Decode happens ahead of stage 0; later stages only delay the result.
  always_comb begin
    dec        = decode_imm(instr_i);
    head.imm   = dec.imm[XLEN-1:0];
    head.typ   = dec.typ;
    head.instr = instr_i;
  end

  // Upper decoder bits are redundant sign copies when XLEN is 32.
  assign unused_dec_hi = ^dec.imm;

  logic vld [0:STAGES];
  logic rdy [0:STAGES];
  pay_t dat [0:STAGES];

  assign vld[0]      = valid_i;
  assign dat[0]      = head;
  assign rdy[STAGES] = ready_i;
  assign ready_o     = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    imm_pipe_stage #(.W(PW)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush_i),
      .up_vld (vld[k]),
      .up_rdy (rdy[k]),
      .up_dat (dat[k]),
      .dn_vld (vld[k+1]),
      .dn_rdy (rdy[k+1]),
      .dn_dat (dat[k+1])
    );
  end

  assign valid_o    = vld[STAGES];
  assign imm_o      = dat[STAGES].imm;
  assign imm_type_o = dat[STAGES].typ;
  assign instr_o    = dat[STAGES].instr;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks on two builds, XLEN=32/STAGES=1 (a_*) and XLEN=64/STAGES=2 (b_*).
// Inputs change on the falling edge; outputs are read 1 time unit after that.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic clk, rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        a_flush, a_valid, a_ready, a_vo, a_ri;
  logic [31:0] a_instr, a_imm, a_instr_o;
  imm_type_e   a_type;

  logic        b_flush, b_valid, b_ready, b_vo, b_ri;
  logic [31:0] b_instr, b_instr_o;
  logic [63:0] b_imm;
  imm_type_e   b_type;

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) dut_a (
    .clk(clk), .rst(rst), .flush_i(a_flush), .valid_i(a_valid), .ready_o(a_ready),
    .instr_i(a_instr), .valid_o(a_vo), .ready_i(a_ri), .imm_o(a_imm),
    .imm_type_o(a_type), .instr_o(a_instr_o)
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .flush_i(b_flush), .valid_i(b_valid), .ready_o(b_ready),
    .instr_i(b_instr), .valid_o(b_vo), .ready_i(b_ri), .imm_o(b_imm),
    .imm_type_o(b_type), .instr_o(b_instr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // addi x1, x0, k
  function automatic logic [31:0] mk_addi(input int k);
    logic [11:0] imm12;
    imm12 = 12'(k);
    return {imm12, 5'd0, 3'd0, 5'd1, 7'b0010011};
  endfunction

  task automatic test_reset;
    #2;
    n_checks++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid: got %b want 0", a_vo); end
    n_checks++; if (a_imm !== 32'h0) begin n_fail++; $display("FAIL rst_a_imm: got %h want 0", a_imm); end
    n_checks++; if (a_type !== IMM_NONE) begin n_fail++; $display("FAIL rst_a_type: got %0d want 0", a_type); end
    n_checks++; if (a_instr_o !== 32'h0) begin n_fail++; $display("FAIL rst_a_instr: got %h want 0", a_instr_o); end
    n_checks++; if (b_vo !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid: got %b want 0", b_vo); end
    n_checks++; if (b_imm !== 64'h0) begin n_fail++; $display("FAIL rst_b_imm: got %h want 0", b_imm); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_ready: got %b want 1", a_ready); end
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL rst_b_ready: got %b want 1", b_ready); end
  endtask

  task automatic test_decode_32;
    logic [31:0] ti   [10];
    logic [31:0] timm [10];
    imm_type_e   tt   [10];
    ti   = '{32'hFFF00093, 32'hFE112E23, 32'h0000007F, 32'hFE000EE3, 32'hFFFFF06F,
             32'h12345017, 32'h00812083, 32'h34011073, 32'h7C0FD073, 32'h000050FD};
    timm = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000000, 32'hFFFFFFFC, 32'hFFFFFFFE,
             32'h12345000, 32'h00000008, 32'h00000000, 32'h0000001F,
`ifdef IMMGEN_RVC_EN
             32'hFFFFFFFF};
`else
             32'h00000000};
`endif
    tt   = '{IMM_I, IMM_S, IMM_NONE, IMM_B, IMM_J, IMM_U, IMM_I, IMM_NONE, IMM_Z,
`ifdef IMMGEN_RVC_EN
             IMM_I};
`else
             IMM_NONE};
`endif
    a_ri = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_valid = 1'b1;
      a_instr = ti[i];
      @(negedge clk);
      a_valid = 1'b0;
      #1;
      n_checks++; if (a_vo !== 1'b1) begin n_fail++; $display("FAIL dec32_valid[%0d]: got %b want 1", i, a_vo); end
      n_checks++; if (a_imm !== timm[i]) begin n_fail++; $display("FAIL dec32_imm[%0d]: got %h want %h", i, a_imm, timm[i]); end
      n_checks++; if (a_type !== tt[i]) begin n_fail++; $display("FAIL dec32_type[%0d]: got %0d want %0d", i, a_type, tt[i]); end
      n_checks++; if (a_instr_o !== ti[i]) begin n_fail++; $display("FAIL dec32_instr[%0d]: got %h want %h", i, a_instr_o, ti[i]); end
    end
    @(negedge clk);
    #1;
    n_checks++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL dec32_drain: got %b want 0", a_vo); end
  endtask

  task automatic test_decode_64;
    logic [31:0] ti   [3];
    logic [63:0] timm [3];
    imm_type_e   tt   [3];
    ti   = '{32'h800002B7, 32'h7C0FD073, 32'hFFF00093};
    timm = '{64'hFFFFFFFF80000000, 64'h000000000000001F, 64'hFFFFFFFFFFFFFFFF};
    tt   = '{IMM_U, IMM_Z, IMM_I};
    b_ri = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_valid = 1'b1;
      b_instr = ti[i];
      @(negedge clk);
      b_valid = 1'b0;
      #1;
      n_checks++; if (b_vo !== 1'b0) begin n_fail++; $display("FAIL dec64_early[%0d]: got %b want 0", i, b_vo); end
      @(negedge clk);
      #1;
      n_checks++; if (b_vo !== 1'b1) begin n_fail++; $display("FAIL dec64_valid[%0d]: got %b want 1", i, b_vo); end
      n_checks++; if (b_imm !== timm[i]) begin n_fail++; $display("FAIL dec64_imm[%0d]: got %h want %h", i, b_imm, timm[i]); end
      n_checks++; if (b_type !== tt[i]) begin n_fail++; $display("FAIL dec64_type[%0d]: got %0d want %0d", i, b_type, tt[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int got  = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      b_ri    = !(c >= 2 && c <= 4);
      b_valid = (sent < 6);
      b_instr = mk_addi(sent + 1);
      #1;
      if (c >= 2 && c <= 4) begin
        n_checks++; if (b_vo !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_valid[c%0d]: got %b want 1", c, b_vo); end
        n_checks++; if (b_imm !== 64'd1) begin n_fail++; $display("FAIL b2b_hold_imm[c%0d]: got %h want 1", c, b_imm); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low[c%0d]: got %b want 0", c, b_ready); end
        n_checks++; if (sent !== 2) begin n_fail++; $display("FAIL b2b_accepts[c%0d]: got %0d want 2", c, sent); end
      end
      if (b_vo && b_ri) begin
        n_checks++;
        if (b_imm !== 64'(got + 1)) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h want %h", got, b_imm, 64'(got + 1)); end
        got++;
      end
      if (b_valid && b_ready) sent++;
    end
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    n_checks++; if (got !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", got); end
    n_checks++; if (b_vo !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", b_vo); end
  endtask

  task automatic test_flush;
    // Two entries in flight in the 2-stage build, then flush with a third presented.
    @(negedge clk);
    b_ri = 1'b0; b_valid = 1'b1; b_instr = mk_addi(10);
    @(negedge clk);
    b_instr = mk_addi(11);
    @(negedge clk);
    b_flush = 1'b1; b_instr = mk_addi(12);
    #1;
    n_checks++; if (b_vo !== 1'b1 || b_imm !== 64'd10) begin n_fail++; $display("FAIL flush_pre: got vld=%b imm=%h want vld=1 imm=a", b_vo, b_imm); end
    @(negedge clk);
    b_flush = 1'b0; b_valid = 1'b0; b_ri = 1'b1;
    #1;
    n_checks++; if (b_vo !== 1'b0) begin n_fail++; $display("FAIL flush_b_valid: got %b want 0", b_vo); end
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL flush_b_ready: got %b want 1", b_ready); end
    b_valid = 1'b1; b_instr = mk_addi(13);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    n_checks++; if (b_vo !== 1'b0) begin n_fail++; $display("FAIL flush_next_early: got %b want 0", b_vo); end
    @(negedge clk);
    #1;
    n_checks++; if (b_vo !== 1'b1 || b_imm !== 64'd13) begin n_fail++; $display("FAIL flush_next: got vld=%b imm=%h want vld=1 imm=d", b_vo, b_imm); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      n_checks++; if (b_vo !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: got vld=%b imm=%h want vld=0", c, b_vo, b_imm); end
    end
    // Single-stage build: flush wins over an accept that ready_o still advertises.
    @(negedge clk);
    a_ri = 1'b1; a_valid = 1'b1; a_instr = 32'hFFF00093; a_flush = 1'b1;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL flush_a_ready: got %b want 1", a_ready); end
    @(negedge clk);
    a_valid = 1'b0; a_flush = 1'b0;
    #1;
    n_checks++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL flush_a_drop: got %b want 0", a_vo); end
  endtask

  task automatic test_garbage;
    a_ri = 1'b1; a_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_instr = $urandom;
      #1;
      n_checks++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL garbage_valid[%0d]: got %b want 0", c, a_vo); end
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    b_ri = 1'b0; b_valid = 1'b1; b_instr = 32'hFFF00093;
    @(negedge clk);
    b_valid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (b_vo !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %b want 1", b_vo); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (b_vo !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", b_vo); end
    n_checks++; if (b_imm !== 64'h0) begin n_fail++; $display("FAIL arst_imm: got %h want 0", b_imm); end
    n_checks++; if (b_type !== IMM_NONE) begin n_fail++; $display("FAIL arst_type: got %0d want 0", b_type); end
    n_checks++; if (b_instr_o !== 32'h0) begin n_fail++; $display("FAIL arst_instr: got %h want 0", b_instr_o); end
    @(negedge clk);
    rst = 1'b0; b_ri = 1'b1;
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", b_ready); end
    @(negedge clk);
    #1;
    n_checks++; if (b_vo !== 1'b0) begin n_fail++; $display("FAIL arst_no_drain: got %b want 0", b_vo); end
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_valid = 1'b0; a_instr = 32'h0; a_ri = 1'b1;
    b_flush = 1'b0; b_valid = 1'b0; b_instr = 32'h0; b_ri = 1'b1;
    test_reset;
    test_decode_32;
    test_decode_64;
    test_back_to_back;
    test_flush;
    test_garbage;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
